// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, the hard-wired zero register and the round-robin pointer step
// used by the register-file writeback arbiter.
package mips_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr with wrap-around
// and returns a one-hot grant plus its binary index.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             enable,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_valid
);
    import mips_wb_pkg::*;

    always_comb begin
        int idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        if (enable) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!grant_valid && req[idx]) begin
                    grant[idx]  = 1'b1;
                    grant_idx   = PTR_W'(idx);
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register-file write port with a registered WE3/A3/WD3.
// Optional WB-stage forwarding from the output register: REGFILE_WB_FWD_EN.
module regfile_wb_arbiter #(
    parameter int NREQ   = 2,
    parameter int DATA_W = mips_wb_pkg::DATA_W,
    parameter int ADDR_W = mips_wb_pkg::REG_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wb_stall,
    output logic                     WE3,
    output logic [ADDR_W-1:0]        A3,
    output logic [DATA_W-1:0]        WD3,
    input  logic [ADDR_W-1:0]        rd_addr1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [DATA_W-1:0]        fwd_data1,
    output logic [DATA_W-1:0]        fwd_data2
);
    import mips_wb_pkg::*;

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              we3_q, we3_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;

    logic [NREQ-1:0]   grant;
    logic [PTR_W-1:0]  gnt_idx;
    logic              handshake;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Reset also masks grants so no requester sees a handshake that cannot land.
    rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (rr_ptr_q),
        .enable      (~wb_stall & ~rst),
        .grant       (grant),
        .grant_idx   (gnt_idx),
        .grant_valid (handshake)
    );

    assign req_ready = grant;
    assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        we3_d    = 1'b0;
        a3_d     = a3_q;
        wd3_d    = wd3_q;
        if (handshake) begin
            rr_ptr_d = PTR_W'(rr_next(int'(gnt_idx), NREQ));
            // A $0 destination still consumes the grant but never strobes the file.
            we3_d    = (sel_addr != ZERO_ADDR);
            a3_d     = sel_addr;
            wd3_d    = sel_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            we3_q    <= 1'b0;
            a3_q     <= '0;
            wd3_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we3_q    <= we3_d;
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
        end
    end

    assign WE3 = we3_q;
    assign A3  = a3_q;
    assign WD3 = wd3_q;

`ifdef REGFILE_WB_FWD_EN
    assign fwd_hit1  = we3_q & (a3_q == rd_addr1) & (a3_q != ZERO_ADDR);
    assign fwd_hit2  = we3_q & (a3_q == rd_addr2) & (a3_q != ZERO_ADDR);
    assign fwd_data1 = wd3_q;
    assign fwd_data2 = wd3_q;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd_addr1, rd_addr2};
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then randomized
// traffic, all checked against a round-robin reference model.
module tb_regfile_wb_arbiter;
    localparam int NREQ   = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   wb_stall;
    logic                   WE3;
    logic [ADDR_W-1:0]      A3;
    logic [DATA_W-1:0]      WD3;
    logic [ADDR_W-1:0]      rd_addr1, rd_addr2;
    logic                   fwd_hit1, fwd_hit2;
    logic [DATA_W-1:0]      fwd_data1, fwd_data2;

    regfile_wb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .wb_stall(wb_stall),
        .WE3(WE3), .A3(A3), .WD3(WD3), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the next requester to favour and the last registered write.
    int                m_ptr;
    bit                m_we;
    logic [ADDR_W-1:0] m_a3;
    logic [DATA_W-1:0] m_wd3;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v, input logic stall);
        if (stall || v == '0) return -1;
        for (int k = 0; k < NREQ; k++)
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_we = 0; m_a3 = '0; m_wd3 = '0;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    // Inputs already driven after a falling edge; checks the grant, forwarding,
    // then the registered write after the next rising edge.
    task automatic eval_cycle(output int g);
        logic [ADDR_W-1:0] ga;
        logic [NREQ-1:0]   exp_ready;
        bit                eh1, eh2;
        #1;
        g = model_grant(req_valid, wb_stall);
        exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
`ifdef REGFILE_WB_FWD_EN
        eh1 = m_we && (m_a3 == rd_addr1) && (m_a3 != 0);
        eh2 = m_we && (m_a3 == rd_addr2) && (m_a3 != 0);
        if (eh1) chk("fwd_data1", 64'(fwd_data1), 64'(m_wd3));
        if (eh2) chk("fwd_data2", 64'(fwd_data2), 64'(m_wd3));
`else
        eh1 = 0; eh2 = 0;
        chk("fwd_data1", 64'(fwd_data1), 64'd0);
`endif
        chk("fwd_hit1", 64'(fwd_hit1), 64'(eh1));
        chk("fwd_hit2", 64'(fwd_hit2), 64'(eh2));
        @(posedge clk);
        if (g >= 0) begin
            ga    = req_addr[g*ADDR_W +: ADDR_W];
            m_a3  = ga;
            m_wd3 = req_data[g*DATA_W +: DATA_W];
            m_we  = (ga != 0);
            m_ptr = (g + 1) % NREQ;
        end else begin
            m_we = 0;
        end
        #1;
        chk("WE3", 64'(WE3), 64'(m_we));
        chk("A3",  64'(A3),  64'(m_a3));
        chk("WD3", 64'(WD3), 64'(m_wd3));
    endtask

    int g;
    bit pend [NREQ];
    int grant_cnt [NREQ];

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        wb_stall = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
        model_reset();

        // Reset state, with valid requests visible while reset is held
        @(negedge clk); @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("rst_WE3", 64'(WE3), 64'd0);
        chk("rst_A3", 64'(A3), 64'd0);
        chk("rst_WD3", 64'(WD3), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0; req_valid = '0;

        // Single requester
        req_valid = 2'b01; set_req(0, 5'd8, 32'hDEADBEEF);
        eval_cycle(g);
        chk("single_WE3", 64'(WE3), 64'd1);
        chk("single_WD3", 64'(WD3), 64'hDEADBEEF);
        @(negedge clk); req_valid = '0;
        eval_cycle(g);

        // Contention: alternation and WE3 held high
        @(negedge clk); model_reset(); rst = 1'b1; #1; @(negedge clk); rst = 1'b0;
        req_valid = 2'b11; set_req(0, 5'd3, 32'hA0A0_0001); set_req(1, 5'd4, 32'hB0B0_0002);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            eval_cycle(g);
            chk("cont_order", 64'(g), 64'(c % 2));
        end
        @(negedge clk); req_valid = '0; eval_cycle(g);

        // $0 destination: handshake completes, no write strobe
        @(negedge clk);
        req_valid = 2'b10; set_req(1, 5'd0, 32'hFFFFFFFF);
        eval_cycle(g);
        chk("zero_WE3", 64'(WE3), 64'd0);

        // Stall with both valid, then resume from the saved pointer
        @(negedge clk);
        req_valid = 2'b11; set_req(0, 5'd5, 32'h5555_0000); set_req(1, 5'd6, 32'h6666_0000);
        wb_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            eval_cycle(g);
        end
        @(negedge clk); wb_stall = 1'b0;
        eval_cycle(g);
        chk("stall_resume", 64'(g), 64'd0);

        // Forwarding during the WE3 cycle
        @(negedge clk);
        req_valid = 2'b01; set_req(0, 5'd9, 32'h12345678);
        eval_cycle(g);
        @(negedge clk);
        req_valid = '0; rd_addr1 = 5'd9; rd_addr2 = 5'd10;
        eval_cycle(g);

        // Asynchronous reset while a write is pending
        @(negedge clk);
        req_valid = 2'b10; set_req(1, 5'd7, 32'h7777_7777);
        eval_cycle(g);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_WE3", 64'(WE3), 64'd0);
        chk("arst_A3", 64'(A3), 64'd0);
        chk("arst_WD3", 64'(WD3), 64'd0);
        chk("arst_ready", 64'(req_ready), 64'd0);
        @(negedge clk); rst = 1'b0;
        req_valid = 2'b11;
        eval_cycle(g);
        chk("arst_first", 64'(g), 64'd0);

        // Randomized traffic; requesters hold their request until granted
        for (int i = 0; i < NREQ; i++) begin pend[i] = 0; grant_cnt[i] = 0; end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1;
                    set_req(i, ($urandom_range(0, 5) == 0) ? 5'd0 : ADDR_W'($urandom_range(0, 31)),
                            DATA_W'($urandom));
                end
                req_valid[i] = pend[i];
            end
            wb_stall = ($urandom_range(0, 7) == 0);
            rd_addr1 = ($urandom_range(0, 1) == 1) ? m_a3 : ADDR_W'($urandom_range(0, 31));
            rd_addr2 = ADDR_W'($urandom_range(0, 31));
            eval_cycle(g);
            if (g >= 0) begin pend[g] = 0; grant_cnt[g]++; end
        end

        // Fairness under continuous contention
        @(negedge clk);
        wb_stall = 1'b0; req_valid = 2'b11;
        for (int i = 0; i < NREQ; i++) grant_cnt[i] = 0;
        for (int c = 0; c < 4 * NREQ; c++) begin
            if (c > 0) @(negedge clk);
            eval_cycle(g);
            if (g >= 0) grant_cnt[g]++;
        end
        for (int i = 0; i < NREQ; i++) chk("fair_cnt", 64'(grant_cnt[i]), 64'd4);

        @(negedge clk); req_valid = '0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (WE3/A3/WD3) between NREQ writeback requesters, e.g. the ALU/load writeback path and a multi-cycle multiply/divide unit.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Drives a registered write port: one-cycle latency from grant to write strobe.
- Sits between the datapath writeback sources and the register file.

Parameters:
- NREQ, 2, number of requesters (2..8)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*ADDR_W  packed destination register; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  packed write data; same packing as req_addr
- req_ready  out  NREQ  one-hot grant; a request completes in the cycle req_valid[i] & req_ready[i]
- wb_stall  in  1  blocks all grants this cycle
- WE3  out  1  register-file write enable, registered
- A3  out  ADDR_W  register-file write address, registered
- WD3  out  DATA_W  register-file write data, registered
- rd_addr1, rd_addr2  in  ADDR_W each  read addresses, used only for forwarding
- fwd_hit1, fwd_hit2  out  1 each  forwarding match
- fwd_data1, fwd_data2  out  DATA_W each  forwarded data

Behaviour:
- Reset, asynchronous: WE3=0, A3=0, WD3=0, rr_ptr=0. req_ready is combinational and is 0 while rst is high.
- Grant, combinational:
  - If wb_stall=1 or no req_valid bit is set, req_ready=0.
  - Otherwise, search from index rr_ptr upward with wrap-around; grant the first i with req_valid[i]=1.
  - Exactly one bit of req_ready is high.
  - req_ready[i] never asserts without req_valid[i].
- Pointer update at the clock edge: on a handshake with requester g, rr_ptr <= (g+1) mod NREQ. With no handshake, rr_ptr holds.
- Output register at the clock edge:
  - On a handshake: A3<=req_addr[g], WD3<=req_data[g], WE3<=(req_addr[g]!=0).
  - With no handshake: WE3<=0; A3 and WD3 hold.
- Register $0: the handshake still completes, but WE3 stays 0, so $0 is never written.
- Latency: handshake at edge k gives WE3 high during cycle k..k+1; the register file captures the write at edge k+1.
- Throughput: one write per cycle. A single requester with continuous valid is granted every cycle.
- Fairness: with all NREQ requesters continuously valid, each is granted once per NREQ cycles.
- Requester rule: a requester holds req_valid, req_addr and req_data stable until it is granted. The arbiter does not check this.
- Same-address collision: two requesters targeting the same register are serialised in round-robin order. The later grant's data is the final register value.
- wb_stall asserted mid-stream: no grant and rr_ptr frozen. The previous registered write still completes, because WE3 was already set.
- Reset mid-operation: a pending WE3 is cleared immediately, so the write is lost. Requesters restart arbitration from index 0.

Optional Feature:
- Macro: REGFILE_WB_FWD_EN.
- Defined: fwd_hitN = WE3 & (A3==rd_addrN) & (A3!=0), and fwd_dataN = WD3. This is purely combinational from the output register and covers the cycle before the register-file write lands.
- Not defined: fwd_hit1/2=0 and fwd_data1/2=0 constantly. The ports remain present so the port list is identical.

Decomposition:
- Package mips_wb_pkg:
  - REG_ADDR_W=5
  - DATA_W=32
  - REG_ZERO=5'd0
  - function rr_next(ptr, n) returning (ptr+1) mod n
- Sub-module rr_arbiter:
  - Inputs: req vector, ptr, enable (=!wb_stall).
  - Output: one-hot grant plus binary grant index. Combinational.
  - Parameterised by NREQ.
- regfile_wb_arbiter holds rr_ptr, the output register and the forwarding logic.

Test Plan:
- Reset: assert rst mid-cycle with WE3=1 -> WE3, A3, WD3 go to 0 immediately, asynchronously. After release, the first grant with both valid goes to requester 0.
- Single requester: req_valid=01, addr=5'd8, data=32'hDEADBEEF -> req_ready=01 the same cycle; next cycle WE3=1, A3=8, WD3=DEADBEEF; the cycle after, WE3=0.
- Contention: both valid continuously for 6 cycles, NREQ=2 -> grants alternate 0,1,0,1,0,1; WE3 stays high for cycles 2..7.
- $0 write: requester 1 writes addr 0, data FFFFFFFF -> req_ready[1]=1; next cycle WE3=0.
- Stall: both valid, wb_stall=1 for 3 cycles -> req_ready=00 and rr_ptr unchanged. After the stall releases, arbitration resumes from the saved pointer.
- Forwarding (macro defined): write addr 9, data 32'h12345678; in the WE3 cycle, drive rd_addr1=9 and rd_addr2=10 -> fwd_hit1=1 with fwd_data1=12345678, and fwd_hit2=0. With the macro undefined, both hits are 0.
